// File: rtl/recovery_rom_arbiter_if.sv
// Core-side fetch ports and ROM-side port of the recovery ROM arbiter, bundled as one interface.
// slave is the arbiter's view; master is the view of the cores and ROM that surround it.
interface recovery_rom_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                       lockstep_i;
  logic [1:0]                 req_i;
  logic [1:0][ADDR_WIDTH-1:0] addr_i;
  logic [1:0]                 gnt_o;
  logic [1:0]                 rvalid_o;
  logic [DATA_WIDTH-1:0]      rdata_o;
  logic                       rom_req_o;
  logic [ADDR_WIDTH-1:0]      rom_addr_o;
  logic [DATA_WIDTH-1:0]      rom_rdata_i;
  logic                       mismatch_o;
  logic                       desync_o;

  modport slave (
    input  lockstep_i, req_i, addr_i, rom_rdata_i,
    output gnt_o, rvalid_o, rdata_o, rom_req_o, rom_addr_o, mismatch_o, desync_o
  );

  modport master (
    output lockstep_i, req_i, addr_i, rom_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, rom_req_o, rom_addr_o, mismatch_o, desync_o
  );
endinterface

// File: rtl/recovery_rom_arbiter.sv
// Shares the recovery ROM between two cores: round-robin when independent, merged fetches in lockstep.
// Latency: grant and ROM strobe combinational; rvalid/rdata and mismatch/desync pulses 1 cycle later.
// Backpressure: cores hold req/addr until granted; responses cannot be stalled.
module recovery_rom_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LS_TIMEOUT = 8
) (
  input logic                   clk_i,
  input logic                   rst_i,
  recovery_rom_arbiter_if.slave bus
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] LS_WAIT = 1'b1;

  localparam int            CW       = $clog2(LS_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LS_TIMEOUT - 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, lone_cnt;
  logic          rr_q, rr_d;
  logic [1:0]    pend_q;
  logic          mismatch_q, mismatch_d;
  logic          desync_q, desync_d;

  logic [1:0] gnt, rr_pick;
  logic       both, lone, addr_eq, timeout;

  assign both     = &bus.req_i;
  assign lone     = ^bus.req_i;
  assign addr_eq  = (bus.addr_i[0] == bus.addr_i[1]);
  assign rr_pick  = rr_q ? 2'b10 : 2'b01;
  // Lone-cycle count only carries over while still waiting for the partner.
  assign lone_cnt = (state_q == LS_WAIT) ? cnt_q : '0;
  assign timeout  = (lone_cnt == CNT_LAST);

  always_comb begin
    gnt        = 2'b00;
    state_d    = IDLE;
    cnt_d      = '0;
    mismatch_d = 1'b0;
    desync_d   = 1'b0;
    if (!bus.lockstep_i) begin
      gnt = both ? rr_pick : bus.req_i;
    end else if (both) begin
      gnt        = addr_eq ? 2'b11 : rr_pick;
      mismatch_d = !addr_eq;
    end else if (lone) begin
      if (timeout) begin
        gnt      = bus.req_i;
        desync_d = 1'b1;
      end else begin
        state_d = LS_WAIT;
        cnt_d   = lone_cnt + CW'(1);
      end
    end
  end

  // A merged grant leaves the pointer alone; any single grant hands priority to the other core.
  always_comb begin
    case (gnt)
      2'b01:   rr_d = 1'b1;
      2'b10:   rr_d = 1'b0;
      default: rr_d = rr_q;
    endcase
  end

  assign bus.gnt_o      = gnt;
  assign bus.rom_req_o  = |gnt;
  assign bus.rom_addr_o = (gnt == 2'b10) ? bus.addr_i[1] : bus.addr_i[0];

  assign bus.rvalid_o   = pend_q;
  assign bus.rdata_o    = DATA_WIDTH'(bus.rom_rdata_i);
  assign bus.mismatch_o = mismatch_q;
  assign bus.desync_o   = desync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rr_q       <= 1'b0;
      pend_q     <= 2'b00;
      mismatch_q <= 1'b0;
      desync_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      pend_q     <= gnt;
      mismatch_q <= mismatch_d;
      desync_q   <= desync_d;
    end
  end

endmodule

// File: tb/tb_recovery_rom_arbiter.sv
// Self-checking bench for recovery_rom_arbiter: vector table, directed corner sequences,
// and randomized traffic against a rule-level reference model.
module tb_recovery_rom_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LST = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  recovery_rom_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  recovery_rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LS_TIMEOUT(LST)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {16'hC0DE, a[17:2]};
  endfunction

  // ROM with one cycle of read latency
  always @(posedge clk) begin
    if (bus.rom_req_o) bus.rom_rdata_i <= rom_word(bus.rom_addr_o);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: who has priority, how long a lone lockstep request has waited,
  // and what should appear on the response side next cycle.
  int          m_prio;
  int          m_waited;
  logic [1:0]  m_pend;
  logic        m_mis, m_des;
  logic [31:0] m_rdata;

  logic [1:0] obs_gnt, obs_rv;
  logic       obs_mis, obs_des;

  task automatic model_reset();
    m_prio = 0; m_waited = 0; m_pend = 2'b00; m_mis = 1'b0; m_des = 1'b0; m_rdata = '0;
  endtask

  task automatic model_eval(input logic lock, input logic [1:0] req, input logic [31:0] a0,
                            input logic [31:0] a1, output logic [1:0] g, output logic mis,
                            output logic des);
    g = 2'b00; mis = 1'b0; des = 1'b0;
    if (req == 2'b11) begin
      if (lock && a0 == a1) g = 2'b11;
      else begin
        g   = (m_prio == 0) ? 2'b01 : 2'b10;
        mis = lock;
      end
    end else if (req != 2'b00) begin
      if (!lock || m_waited + 1 == LST) begin
        g   = req;
        des = lock;
      end
    end
  endtask

  task automatic step(input logic lock, input logic [1:0] req, input logic [31:0] a0,
                      input logic [31:0] a1);
    logic [1:0] eg;
    logic       emis, edes;
    bus.lockstep_i = lock;
    bus.req_i      = req;
    bus.addr_i[0]  = a0;
    bus.addr_i[1]  = a1;
    @(negedge clk);
    model_eval(lock, req, a0, a1, eg, emis, edes);
    obs_gnt = bus.gnt_o; obs_rv = bus.rvalid_o; obs_mis = bus.mismatch_o; obs_des = bus.desync_o;
    chk("gnt", {62'd0, bus.gnt_o}, {62'd0, eg});
    chk("rom_req", {63'd0, bus.rom_req_o}, {63'd0, |eg});
    if (eg != 2'b00) chk("rom_addr", {32'd0, bus.rom_addr_o}, {32'd0, (eg == 2'b10) ? a1 : a0});
    chk("rvalid", {62'd0, bus.rvalid_o}, {62'd0, m_pend});
    if (m_pend != 2'b00) chk("rdata", {32'd0, bus.rdata_o}, {32'd0, m_rdata});
    chk("mismatch", {63'd0, bus.mismatch_o}, {63'd0, m_mis});
    chk("desync", {63'd0, bus.desync_o}, {63'd0, m_des});
    m_pend = eg; m_mis = emis; m_des = edes;
    if (eg != 2'b00) m_rdata = rom_word((eg == 2'b10) ? a1 : a0);
    if (eg == 2'b01) m_prio = 1;
    else if (eg == 2'b10) m_prio = 0;
    if (lock && (req == 2'b01 || req == 2'b10) && eg == 2'b00) m_waited++;
    else m_waited = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_i = 2'b00; bus.lockstep_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic        lock;
    logic [1:0]  req;
    logic [31:0] a0, a1;
    logic [1:0]  gnt, rv;
    logic        mis, des;
  } vec_t;

  vec_t tbl[14];

  logic [1:0]  rq;
  logic [31:0] ra[2];
  logic        lk;

  initial begin
    bus.rom_rdata_i = '0;
    bus.req_i = 2'b00; bus.lockstep_i = 1'b0; bus.addr_i = '0;
    model_reset();

    tbl[0]  = '{1'b0, 2'b11, 32'h0,  32'h8,  2'b01, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'b11, 32'h0,  32'h8,  2'b10, 2'b01, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 2'b11, 32'h0,  32'h8,  2'b01, 2'b10, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 2'b11, 32'h0,  32'h8,  2'b10, 2'b01, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 2'b01, 32'h4,  32'h8,  2'b01, 2'b10, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 2'b00, 32'h4,  32'h8,  2'b00, 2'b01, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 2'b11, 32'h10, 32'h10, 2'b11, 2'b00, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 2'b00, 32'h10, 32'h10, 2'b00, 2'b11, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 2'b11, 32'h4,  32'h8,  2'b10, 2'b00, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 2'b01, 32'h4,  32'h8,  2'b00, 2'b10, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 2'b01, 32'h4,  32'h8,  2'b00, 2'b00, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 2'b00, 32'h4,  32'h8,  2'b00, 2'b00, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 2'b10, 32'h4,  32'h8,  2'b10, 2'b00, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 2'b00, 32'h4,  32'h8,  2'b00, 2'b10, 1'b0, 1'b0};

    do_reset();
    chk("reset_rvalid", {62'd0, bus.rvalid_o}, 64'd0);
    chk("reset_mismatch", {63'd0, bus.mismatch_o}, 64'd0);
    chk("reset_desync", {63'd0, bus.desync_o}, 64'd0);

    foreach (tbl[i]) begin
      step(tbl[i].lock, tbl[i].req, tbl[i].a0, tbl[i].a1);
      chk($sformatf("tbl%0d_gnt", i), {62'd0, obs_gnt}, {62'd0, tbl[i].gnt});
      chk($sformatf("tbl%0d_rvalid", i), {62'd0, obs_rv}, {62'd0, tbl[i].rv});
      chk($sformatf("tbl%0d_mismatch", i), {63'd0, obs_mis}, {63'd0, tbl[i].mis});
      chk($sformatf("tbl%0d_desync", i), {63'd0, obs_des}, {63'd0, tbl[i].des});
    end

    // Lone lockstep requester: held off LS_TIMEOUT-1 cycles, then granted with a desync pulse
    do_reset();
    for (int k = 0; k < LST - 1; k++) begin
      step(1'b1, 2'b10, 32'h0, 32'h8);
      chk("t4_wait_gnt", {62'd0, obs_gnt}, 64'd0);
    end
    step(1'b1, 2'b10, 32'h0, 32'h8);
    chk("t4_timeout_gnt", {62'd0, obs_gnt}, 64'd2);
    step(1'b1, 2'b00, 32'h0, 32'h8);
    chk("t4_desync_pulse", {63'd0, obs_des}, 64'd1);
    chk("t4_rvalid", {62'd0, obs_rv}, 64'd2);
    step(1'b1, 2'b00, 32'h0, 32'h8);
    chk("t4_desync_end", {63'd0, obs_des}, 64'd0);

    // Divergent lockstep fetch straight after reset
    do_reset();
    step(1'b1, 2'b11, 32'h4, 32'h8);
    chk("t5_first_gnt", {62'd0, obs_gnt}, 64'd1);
    step(1'b1, 2'b11, 32'h4, 32'h8);
    chk("t5_second_gnt", {62'd0, obs_gnt}, 64'd2);
    chk("t5_mismatch", {63'd0, obs_mis}, 64'd1);
    step(1'b0, 2'b00, 32'h4, 32'h8);

    // Reset right after a grant drops the response
    do_reset();
    step(1'b0, 2'b01, 32'h4, 32'h0);
    do_reset();
    step(1'b0, 2'b11, 32'h0, 32'h8);
    chk("t6_rvalid_cleared", {62'd0, obs_rv}, 64'd0);
    chk("t6_flags_cleared", {62'd0, obs_mis, obs_des}, 64'd0);
    chk("t6_first_gnt", {62'd0, obs_gnt}, 64'd1);
    step(1'b0, 2'b00, 32'h0, 32'h8);

    // Leaving lockstep mid-wait grants at once, and the lone count restarts afterwards
    do_reset();
    for (int k = 0; k < 3; k++) step(1'b1, 2'b01, 32'hC, 32'h0);
    step(1'b0, 2'b01, 32'hC, 32'h0);
    chk("fall_gnt", {62'd0, obs_gnt}, 64'd1);
    for (int k = 0; k < LST - 1; k++) begin
      step(1'b1, 2'b01, 32'hC, 32'h0);
      chk("rise_wait_gnt", {62'd0, obs_gnt}, 64'd0);
    end
    step(1'b1, 2'b01, 32'hC, 32'h0);
    chk("rise_timeout_gnt", {62'd0, obs_gnt}, 64'd1);
    step(1'b0, 2'b00, 32'h0, 32'h0);

    // Random traffic; a requester keeps its address until granted
    do_reset();
    rq = 2'b00; ra[0] = '0; ra[1] = '0; lk = 1'b0; obs_gnt = 2'b00;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (!(rq[c] && !obs_gnt[c])) begin
          rq[c] = ($urandom_range(0, 2) != 0);
          ra[c] = 32'($urandom_range(0, 3)) << 2;
        end
      end
      if ($urandom_range(0, 15) == 0) lk = ~lk;
      step(lk, rq, ra[0], ra[1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
